// File: rtl/tetris_pkg.sv
// Shared types and board constants for the 4x8 block game.
// Used by game_sequencer and row_clear_step.
package tetris_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    FALL,
    LOCK,
    CLEAR,
    OVER
  } state_t;

  localparam int ROW_W = 4;
  localparam int ROWS  = 8;

  localparam logic [31:0] COL0_MASK = 32'h1111_1111;
  localparam logic [31:0] COL3_MASK = 32'h8888_8888;
  localparam logic [31:0] ROW7_MASK = 32'hF000_0000;

  localparam logic [31:0] SHAPE_1  = 32'h0000_0002;
  localparam logic [31:0] SHAPE_2  = 32'h0000_0006;
  localparam logic [31:0] SHAPE_SQ = 32'h0000_0066;
  localparam logic [31:0] SHAPE_L  = 32'h0000_0062;

  function automatic logic [31:0] spawn_mask(
    input logic [1:0] sel
  );
    logic [31:0] m;
    m = SHAPE_1;
    unique case (sel)
      2'b00: m = SHAPE_1;
      2'b01: m = SHAPE_2;
      2'b10: m = SHAPE_SQ;
      2'b11: m = SHAPE_L;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Control/status bundle between input logic, the sequencer
// and the display driver.
interface game_sequencer_if;

  logic        start;
  logic [1:0]  piece_sel;
  logic        move_left;
  logic        move_right;
  logic        drop;
  logic [31:0] board_out;
  logic        busy;
  logic        game_over;
  logic [7:0]  lines_cleared;

  modport master (
    output start, piece_sel,
    output move_left, move_right, drop,
    input  board_out, busy,
    input  game_over, lines_cleared
  );

  modport slave (
    input  start, piece_sel,
    input  move_left, move_right, drop,
    output board_out, busy,
    output game_over, lines_cleared
  );

endinterface

// File: rtl/row_clear_step.sv
// Removes the highest-index full row; rows above shift down
// one and row 0 becomes empty.
module row_clear_step
  import tetris_pkg::*;
(
  input  logic [31:0] board,
  output logic        found,
  output logic [31:0] board_next
);

  logic        w_found;
  logic [5:0]  w_sh;
  logic [31:0] w_keep;

  // Rows below the removed one keep their place.
  always_comb begin
    w_found = 1'b0;
    w_sh    = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (&board[r*ROW_W +: ROW_W]) begin
        w_found = 1'b1;
        w_sh    = 6'((r + 1) * ROW_W);
      end
    end
    w_keep = 32'hFFFF_FFFF << w_sh;
  end

  assign found      = w_found;
  assign board_next = w_found
    ? ((board & w_keep) |
       ((board << ROW_W) & ~w_keep))
    : board;

endmodule

// File: rtl/game_sequencer.sv
// Play controller: spawn, gravity, moves, lock, line clear.
// Define SCORE_EN to build the lines_cleared counter.
module game_sequencer
  import tetris_pkg::*;
#(
  parameter int TICK_DIV = 8
) (
  input  logic             clka,
  input  logic             rst_n,
  game_sequencer_if.slave  bus
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST =
    CW'(TICK_DIV - 1);

  state_t        r_state;
  state_t        w_next;
  logic [31:0]   r_settled;
  logic [31:0]   r_piece;
  logic [31:0]   r_board;
  logic [CW-1:0] r_tick;

  logic [31:0] w_mask;
  logic [31:0] w_target;
  logic [31:0] w_cleared;
  logic        w_spawn_hit;
  logic        w_fall;
  logic        w_hit;
  logic        w_left_ok;
  logic        w_right_ok;
  logic        w_found;
  logic        w_busy;
  logic        w_over;
  logic        w_restart;

  row_clear_step u_clear (
    .board      (r_settled),
    .found      (w_found),
    .board_next (w_cleared)
  );

  assign w_restart   = bus.start &&
    (r_state == IDLE || r_state == OVER);
  assign w_mask      = spawn_mask(bus.piece_sel);
  assign w_spawn_hit = (w_mask & r_settled) != '0;
  assign w_fall      = (r_tick == TICK_LAST) || bus.drop;
  assign w_target    = r_piece << ROW_W;
  assign w_hit       = ((r_piece & ROW7_MASK) != '0) ||
                       ((w_target & r_settled) != '0);

  // A move only counts when it is the sole request.
  assign w_left_ok = bus.move_left && !bus.move_right &&
    ((r_piece & COL0_MASK) == '0) &&
    (((r_piece >> 1) & r_settled) == '0);
  assign w_right_ok = bus.move_right && !bus.move_left &&
    ((r_piece & COL3_MASK) == '0) &&
    (((r_piece << 1) & r_settled) == '0);

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, OVER: if (bus.start) w_next = SPAWN;
      SPAWN:      w_next = w_spawn_hit ? OVER : FALL;
      FALL:       if (w_fall && w_hit) w_next = LOCK;
      LOCK:       w_next = CLEAR;
      CLEAR:      if (!w_found) w_next = SPAWN;
      default:    w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_over = 1'b0;
    unique case (r_state)
      CLEAR, SPAWN: w_busy = 1'b1;
      OVER:         w_over = 1'b1;
      default:      ;
    endcase
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_settled <= '0;
      r_piece   <= '0;
      r_tick    <= '0;
    end else begin
      unique case (r_state)
        IDLE, OVER: begin
          if (bus.start) begin
            r_settled <= '0;
            r_piece   <= '0;
          end
        end
        SPAWN: begin
          if (!w_spawn_hit) begin
            r_piece <= w_mask;
            r_tick  <= '0;
          end
        end
        FALL: begin
          r_tick <= (r_tick == TICK_LAST)
            ? '0 : r_tick + 1'b1;
          if (w_fall) begin
            if (!w_hit) r_piece <= w_target;
          end else if (w_left_ok) begin
            r_piece <= r_piece >> 1;
          end else if (w_right_ok) begin
            r_piece <= r_piece << 1;
          end
        end
        LOCK: begin
          r_settled <= r_settled | r_piece;
          r_piece   <= '0;
        end
        CLEAR: begin
          if (w_found) r_settled <= w_cleared;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) r_board <= '0;
    else        r_board <= r_settled | r_piece;
  end

`ifdef SCORE_EN
  logic [7:0] r_lines;

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_lines <= '0;
    end else if (w_restart) begin
      r_lines <= '0;
    end else if (r_state == CLEAR && w_found &&
                 r_lines != 8'hFF) begin
      r_lines <= r_lines + 8'd1;
    end
  end

  assign bus.lines_cleared = r_lines;
`else
  assign bus.lines_cleared = 8'd0;
`endif

  assign bus.board_out = r_board;
  assign bus.busy      = w_busy;
  assign bus.game_over = w_over;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: spawn, gravity, moves,
// double line clear, game over and async reset mid-clear.
module tb_game_sequencer;

  logic clka = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

`ifdef SCORE_EN
  localparam bit SCORE = 1'b1;
`else
  localparam bit SCORE = 1'b0;
`endif

  game_sequencer_if u_if ();

  game_sequencer #(.TICK_DIV(8)) dut (
    .clka  (clka),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  always #5 clka = ~clka;

  task automatic step;
    @(posedge clka);
    #1;
  endtask

  task automatic wait_busy(input logic val, input string tag);
    int n;
    n = 0;
    while (u_if.busy !== val && n < 200) begin
      step;
      n++;
    end
    checks++;
    if (u_if.busy !== val) begin
      errors++;
      $display("FAIL %s timeout busy=%b want=%b",
               tag, u_if.busy, val);
    end
  endtask

  task automatic do_reset;
    rst_n           = 1'b0;
    u_if.start      = 1'b0;
    u_if.piece_sel  = 2'b00;
    u_if.move_left  = 1'b0;
    u_if.move_right = 1'b0;
    u_if.drop       = 1'b0;
    repeat (2) step;
    rst_n = 1'b1;
    step;
  endtask

  task automatic start_game(input logic [1:0] sel);
    u_if.start     = 1'b1;
    u_if.piece_sel = sel;
    step;
    u_if.start = 1'b0;
    wait_busy(1'b0, "start");
  endtask

  task automatic place(input logic [1:0] nxt,
                       input int nl, input int nr);
    for (int i = 0; i < nl; i++) begin
      u_if.move_left = 1'b1;
      step;
      u_if.move_left = 1'b0;
    end
    for (int i = 0; i < nr; i++) begin
      u_if.move_right = 1'b1;
      step;
      u_if.move_right = 1'b0;
    end
    u_if.drop = 1'b1;
    wait_busy(1'b1, "lock");
    u_if.piece_sel = nxt;
    u_if.drop = 1'b0;
    wait_busy(1'b0, "respawn");
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    u_if.start = 1'b0;
    u_if.piece_sel = 2'b00;
    u_if.move_left = 1'b0;
    u_if.move_right = 1'b0;
    u_if.drop = 1'b0;
    step;
    checks++;
    if (u_if.board_out !== 32'h0) begin
      errors++;
      $display("FAIL rst_board got=%h exp=0", u_if.board_out);
    end
    checks++;
    if (u_if.busy !== 1'b0 || u_if.game_over !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags busy=%b over=%b exp=0/0",
               u_if.busy, u_if.game_over);
    end
    checks++;
    if (u_if.lines_cleared !== 8'd0) begin
      errors++;
      $display("FAIL rst_lines got=%0d exp=0",
               u_if.lines_cleared);
    end
  endtask

  task automatic test_spawn_drop;
    logic [31:0] exp_b;
    do_reset;
    start_game(2'b10);
    u_if.drop = 1'b1;
    step;
    checks++;
    if (u_if.board_out !== 32'h0000_0066) begin
      errors++;
      $display("FAIL sq_spawn got=%h exp=00000066",
               u_if.board_out);
    end
    step;
    checks++;
    if (u_if.board_out !== 32'h0000_0660) begin
      errors++;
      $display("FAIL sq_drop1 got=%h exp=00000660",
               u_if.board_out);
    end
    repeat (4) step;
    u_if.drop = 1'b0;
    step;
    checks++;
    if (u_if.board_out !== 32'h6600_0000) begin
      errors++;
      $display("FAIL sq_bottom got=%h exp=66000000",
               u_if.board_out);
    end
    u_if.drop = 1'b1;
    step;
    u_if.drop = 1'b0;
    checks++;
    if (u_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL sq_lock_busy got=%b exp=0", u_if.busy);
    end
    step;
    checks++;
    if (u_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL sq_clear_busy got=%b exp=1", u_if.busy);
    end
    repeat (3) step;
    exp_b = 32'h6600_0066;
    checks++;
    if (u_if.board_out !== exp_b) begin
      errors++;
      $display("FAIL sq_respawn got=%h exp=%h",
               u_if.board_out, exp_b);
    end
  endtask

  task automatic test_gravity;
    do_reset;
    start_game(2'b00);
    step;
    checks++;
    if (u_if.board_out !== 32'h2) begin
      errors++;
      $display("FAIL grav_t1 got=%h exp=00000002",
               u_if.board_out);
    end
    repeat (7) step;
    checks++;
    if (u_if.board_out !== 32'h2) begin
      errors++;
      $display("FAIL grav_t8 got=%h exp=00000002",
               u_if.board_out);
    end
    step;
    checks++;
    if (u_if.board_out !== 32'h20) begin
      errors++;
      $display("FAIL grav_t9 got=%h exp=00000020",
               u_if.board_out);
    end
    repeat (7) step;
    checks++;
    if (u_if.board_out !== 32'h20) begin
      errors++;
      $display("FAIL grav_t16 got=%h exp=00000020",
               u_if.board_out);
    end
    step;
    checks++;
    if (u_if.board_out !== 32'h200) begin
      errors++;
      $display("FAIL grav_t17 got=%h exp=00000200",
               u_if.board_out);
    end
  endtask

  task automatic test_moves;
    bit ml [10] = '{1, 1, 0, 0, 0, 0, 1, 1, 0, 0};
    bit mr [10] = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0};
    logic [31:0] eb [10] = '{
      32'h2, 32'h1, 32'h1, 32'h2, 32'h4,
      32'h8, 32'h8, 32'h8, 32'h80, 32'h80
    };
    do_reset;
    start_game(2'b00);
    for (int i = 0; i < 10; i++) begin
      u_if.move_left  = ml[i];
      u_if.move_right = mr[i];
      step;
      checks++;
      if (u_if.board_out !== eb[i]) begin
        errors++;
        $display("FAIL move_%0d got=%h exp=%h",
                 i, u_if.board_out, eb[i]);
      end
    end
    u_if.move_left  = 1'b0;
    u_if.move_right = 1'b0;
  endtask

  task automatic test_double_clear;
    logic [31:0] eb [4] = '{
      32'hFF10_0000, 32'hFF10_0000,
      32'hF100_0000, 32'h1000_0000
    };
    int n;
    do_reset;
    start_game(2'b00);
    place(2'b00, 1, 0);
    place(2'b00, 1, 0);
    place(2'b00, 1, 0);
    place(2'b00, 0, 2);
    place(2'b10, 0, 2);
    checks++;
    if (u_if.board_out !== 32'h9910_0000) begin
      errors++;
      $display("FAIL stack got=%h exp=99100000",
               u_if.board_out);
    end
    step;
    checks++;
    if (u_if.board_out !== 32'h9910_0066) begin
      errors++;
      $display("FAIL stack_sq got=%h exp=99100066",
               u_if.board_out);
    end
    u_if.drop = 1'b1;
    wait_busy(1'b1, "sq_lock");
    u_if.drop = 1'b0;
    u_if.piece_sel = 2'b00;
    n = 0;
    while (u_if.busy === 1'b1 && n < 4) begin
      checks++;
      if (u_if.board_out !== eb[n]) begin
        errors++;
        $display("FAIL clr_board_%0d got=%h exp=%h",
                 n, u_if.board_out, eb[n]);
      end
      n++;
      step;
    end
    checks++;
    if (n != 4 || u_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_cycles got=%0d exp=4 busy=%b",
               n, u_if.busy);
    end
    checks++;
    if (u_if.board_out !== 32'h1000_0000) begin
      errors++;
      $display("FAIL clr_final got=%h exp=10000000",
               u_if.board_out);
    end
    checks++;
    if (u_if.lines_cleared !== (SCORE ? 8'd2 : 8'd0)) begin
      errors++;
      $display("FAIL clr_lines got=%0d exp=%0d",
               u_if.lines_cleared, SCORE ? 2 : 0);
    end
    step;
    checks++;
    if (u_if.board_out !== 32'h1000_0002) begin
      errors++;
      $display("FAIL clr_next got=%h exp=10000002",
               u_if.board_out);
    end
  endtask

  task automatic test_game_over;
    int n;
    do_reset;
    start_game(2'b00);
    u_if.drop = 1'b1;
    n = 0;
    while (u_if.game_over !== 1'b1 && n < 400) begin
      step;
      n++;
    end
    checks++;
    if (u_if.game_over !== 1'b1) begin
      errors++;
      $display("FAIL over_reach got=%b exp=1", u_if.game_over);
    end
    checks++;
    if (u_if.board_out !== 32'h2222_2222) begin
      errors++;
      $display("FAIL over_board got=%h exp=22222222",
               u_if.board_out);
    end
    u_if.move_left = 1'b1;
    repeat (3) step;
    u_if.move_left = 1'b0;
    u_if.drop = 1'b0;
    checks++;
    if (u_if.board_out !== 32'h2222_2222 ||
        u_if.game_over !== 1'b1 || u_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL over_hold got=%h over=%b busy=%b exp=22222222/1/0",
               u_if.board_out, u_if.game_over, u_if.busy);
    end
    u_if.start = 1'b1;
    step;
    u_if.start = 1'b0;
    checks++;
    if (u_if.game_over !== 1'b0 || u_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL over_restart over=%b busy=%b exp=0/1",
               u_if.game_over, u_if.busy);
    end
    step;
    checks++;
    if (u_if.board_out !== 32'h0) begin
      errors++;
      $display("FAIL over_clear got=%h exp=0", u_if.board_out);
    end
    step;
    checks++;
    if (u_if.board_out !== 32'h2) begin
      errors++;
      $display("FAIL over_spawn got=%h exp=00000002",
               u_if.board_out);
    end
  endtask

  task automatic test_reset_mid_clear;
    do_reset;
    start_game(2'b00);
    place(2'b00, 1, 0);
    place(2'b00, 0, 0);
    place(2'b00, 0, 1);
    u_if.move_right = 1'b1;
    step;
    step;
    u_if.move_right = 1'b0;
    u_if.drop = 1'b1;
    wait_busy(1'b1, "row_lock");
    u_if.drop = 1'b0;
    checks++;
    if (u_if.board_out !== 32'hF000_0000) begin
      errors++;
      $display("FAIL row_full got=%h exp=F0000000",
               u_if.board_out);
    end
    step;
    checks++;
    if (u_if.busy !== 1'b1 ||
        u_if.lines_cleared !== (SCORE ? 8'd1 : 8'd0)) begin
      errors++;
      $display("FAIL row_clr busy=%b lines=%0d exp=1/%0d",
               u_if.busy, u_if.lines_cleared, SCORE ? 1 : 0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (u_if.board_out !== 32'h0 || u_if.busy !== 1'b0 ||
        u_if.game_over !== 1'b0) begin
      errors++;
      $display("FAIL async_rst board=%h busy=%b over=%b exp=0",
               u_if.board_out, u_if.busy, u_if.game_over);
    end
    checks++;
    if (u_if.lines_cleared !== 8'd0) begin
      errors++;
      $display("FAIL async_lines got=%0d exp=0",
               u_if.lines_cleared);
    end
    step;
    rst_n = 1'b1;
    u_if.drop = 1'b1;
    u_if.move_left = 1'b1;
    repeat (3) step;
    u_if.drop = 1'b0;
    u_if.move_left = 1'b0;
    checks++;
    if (u_if.board_out !== 32'h0 || u_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold board=%h busy=%b exp=0/0",
               u_if.board_out, u_if.busy);
    end
  endtask

  initial begin
    test_reset;
    test_spawn_drop;
    test_gravity;
    test_moves;
    test_double_clear;
    test_game_over;
    test_reset_mid_clear;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
